pong_match_controller: RTL

Match sequencer for Pong; sits between the collision/scoring logic and the ball motion FSM. It turns the per-cycle bounce event code into single, debounced point awards, holds the authoritative match score, and gates ball motion through serve, play, pause, point and game-over phases. It drives ball run/respawn/serve-direction controls and the score/winner outputs for the display.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/pong_serve_timer.sv | 40 ++++
 rtl/pong_match_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the Pong match controller: FSM states, bounce event
// codes, screen geometry and a saturating score increment.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERVE_WAIT = 3'd1,
        PLAY       = 3'd2,
        PAUSED     = 3'd3,
        POINT      = 3'd4,
        GAME_OVER  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        BOUNCE_NONE   = 2'd0,
        BOUNCE_PADDLE = 2'd1,
        BOUNCE_WALL   = 2'd2,
        BOUNCE_OUT    = 2'd3
    } bounce_e;

    localparam int unsigned SCREEN_X = 640;
    localparam int unsigned SCREEN_Y = 480;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_serve_timer.sv
// Counts frame_tick pulses while enabled; done holds once the serve delay is
// reached and the count parks there until cleared.
module pong_serve_timer #(
    parameter int unsigned DELAY = 60
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic done
);
    localparam logic [7:0] DELAY_C = 8'(DELAY);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear wins, otherwise count ticks up to the delay and park.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (tick && (count_q != DELAY_C)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == DELAY_C);

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer for Pong: debounces out-of-bounds events into point awards,
// keeps the score and gates ball motion through serve/play/pause/point phases.
module pong_match_controller #(
    parameter int unsigned WIN_SCORE          = 9,
    parameter int unsigned SERVE_DELAY_FRAMES = 60,
    parameter int unsigned SCREEN_X           = 640
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] bounce,
    input  logic [9:0] ball_pos_x,
    output logic       ball_run,
    output logic       ball_respawn,
    output logic       serve_dir,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);
    import pong_pkg::*;

    localparam logic [9:0] MID_X = 10'(SCREEN_X / 2);
    localparam logic [3:0] WIN_C = 4'(WIN_SCORE);

    state_e     state_q;
    logic       ball_run_q;
    logic       ball_respawn_q;
    logic       serve_dir_q;
    logic [3:0] score_1_q;
    logic [3:0] score_2_q;
    logic       game_over_q;
    logic       winner_q;
    logic       out_prev_q;
    logic       last_scorer_q;

    logic       out_evt_s;
    logic       serve_done_s;
    logic       timer_clear_s;
    logic       match_won_s;

    // Rising edge of the out-of-bounds code, so a held 11 counts once.
    assign out_evt_s     = (bounce == BOUNCE_OUT) && !out_prev_q;
    assign timer_clear_s = (state_q != SERVE_WAIT);
    assign match_won_s   = last_scorer_q ? (score_2_q == WIN_C) : (score_1_q == WIN_C);

    pong_serve_timer #(
        .DELAY (SERVE_DELAY_FRAMES)
    ) u_serve_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear_s),
        .tick  (frame_tick),
        .done  (serve_done_s)
    );

    // Match FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            ball_run_q     <= 1'b0;
            ball_respawn_q <= 1'b0;
            serve_dir_q    <= 1'b1;
            score_1_q      <= 4'd0;
            score_2_q      <= 4'd0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            out_prev_q     <= 1'b0;
            last_scorer_q  <= 1'b0;
        end else begin
            out_prev_q     <= (bounce == BOUNCE_OUT);
            ball_respawn_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ball_run_q <= 1'b0;
                    if (start) begin
                        state_q        <= SERVE_WAIT;
                        score_1_q      <= 4'd0;
                        score_2_q      <= 4'd0;
                        ball_respawn_q <= 1'b1;
                    end
                end
                SERVE_WAIT: begin
                    if (serve_done_s) begin
                        state_q    <= PLAY;
                        ball_run_q <= 1'b1;
                    end
                end
                PLAY: begin
                    // The ball is served back toward whoever conceded.
                    if (out_evt_s) begin
                        state_q    <= POINT;
                        ball_run_q <= 1'b0;
                        if (ball_pos_x < MID_X) begin
                            score_2_q     <= sat_inc4(score_2_q);
                            serve_dir_q   <= 1'b0;
                            last_scorer_q <= 1'b1;
                        end else begin
                            score_1_q     <= sat_inc4(score_1_q);
                            serve_dir_q   <= 1'b1;
                            last_scorer_q <= 1'b0;
                        end
                    end else if (pause) begin
                        state_q    <= PAUSED;
                        ball_run_q <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state_q    <= PLAY;
                        ball_run_q <= 1'b1;
                    end
                end
                POINT: begin
                    if (match_won_s) begin
                        state_q     <= GAME_OVER;
                        game_over_q <= 1'b1;
                        winner_q    <= last_scorer_q;
                    end else begin
                        state_q        <= SERVE_WAIT;
                        ball_respawn_q <= 1'b1;
                    end
                end
                GAME_OVER: begin
                    ball_run_q <= 1'b0;
                    if (start) begin
                        state_q        <= SERVE_WAIT;
                        score_1_q      <= 4'd0;
                        score_2_q      <= 4'd0;
                        game_over_q    <= 1'b0;
                        ball_respawn_q <= 1'b1;
                        serve_dir_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    ball_run_q  <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign ball_run     = ball_run_q;
    assign ball_respawn = ball_respawn_q;
    assign serve_dir    = serve_dir_q;
    assign score_1      = score_1_q;
    assign score_2      = score_2_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign state        = state_q;

endmodule
